octave_tone_gen: RTL
====================

# octave_tone_gen

Square-wave tone generator that consumes the 2-bit octave selection produced by the octave state machine. It converts it, together with a base note half-period, into an audible square wave. The block sits between the note-to-divisor lookup and the audio output stage. Octave index 0 is the highest octave, and each increment halves the frequency. Octave and pitch changes apply glitch-free at half-period boundaries.

## Interface
- DIV_W, 16, width of base half-period input, in clk cycles
- CNT_W, DIV_W+3, internal counter width; derived localparam, not overridable
- clk  input  1  system clock, rising edge
- nrst  input  1  reset, synchronous, active-low
- en  input  1  tone enable (key held)
- half_period  input  DIV_W  base half-period for octave 0, in clk cycles; 0 = silence
- oct_switch  input  2  octave index 0..3 (0 highest)
- wave_out  output  1  square-wave tone
- period_start  output  1  one-cycle pulse coincident with each 0->1 transition of wave_out

## Operation
- Effective half-period: eff = half_period << oct_switch, computed in CNT_W bits; no overflow possible (max 0xFFFF<<3 = 0x7FFF8).
- Shadow registers: half_period and oct_switch are latched on IDLE->RUN entry and at every toggle. Input changes between latches have no effect until the next boundary.
- States:
  - IDLE: cnt=0, wave_out=0, period_start=0.
    - Move to RUN when en=1 and half_period!=0; latch shadows and set cnt=0.
  - RUN: cnt increments each cycle.
    - When cnt == eff_latched-1: toggle wave_out, clear cnt, relatch shadows.
    - If the relatched half_period is 0: go to IDLE, force wave_out=0.
- en=0 in RUN: next edge goes to IDLE; cnt=0 and wave_out=0, regardless of phase.
- en=1 with half_period=0 in IDLE: stays in IDLE.
- period_start is 1 exactly on the cycle wave_out first reads 1 after a 0->1 toggle; 0 otherwise.
- Simultaneous en fall and toggle boundary: en fall wins (IDLE, wave_out=0, no period_start).

## Timing
- Reset (nrst=0 at an edge): state=IDLE, cnt=0, wave_out=0, period_start=0, shadows=0. Reset overrides all other inputs, including mid-period.
- Entry latency: en sampled 1 at edge E0 means wave_out rises at edge E0+eff, so wave_out is high starting eff cycles after entry.
- Steady state: wave_out high for eff cycles, low for eff cycles; full period 2*eff.
- Octave change mid-half-period: the current half-period completes at its old length, and the new length starts at the next toggle.
- half_period=1, oct=0: wave_out toggles every cycle (period 2 clk).

## Configuration
- OCTAVE_TONE_RESTART_EN:
  - Defined: a change of oct_switch vs. the latched octave while in RUN restarts the phase on the next edge. cnt=0, wave_out=0, shadows relatched, no period_start.
  - Undefined: octave changes take effect only at the next toggle boundary, as described in Operation.

## Structure
- Shared package synth_pkg holds:
  - typedef octave_t (logic [1:0])
  - OCT_MAX = 2'd3
  - default DIV_W
  - state enum tone_state_t {IDLE, RUN}
- One combinational sub-module: octave_period_calc (half_period, octave_t -> CNT_W effective half-period). It is reused by any future multi-voice generator.
- Remaining registers (state, cnt, shadows, wave_out, period_start) stay in octave_tone_gen.

## Test plan
- Reset, then en=1, half_period=5, oct=0 -> wave_out rises 5 cycles after en sampled, toggles every 5 cycles, period_start pulses every 10 cycles.
- half_period=5, oct=2 -> half-period 20 cycles; switch to oct=3 at cnt=7 -> current half ends at 20, the following halves are 40 cycles. With OCTAVE_TONE_RESTART_EN: wave_out=0 and cnt=0 one cycle after the change.
- half_period=16'hFFFF, oct=3 -> half-period exactly 524280 cycles; check no counter wrap.
- en dropped mid-high phase -> wave_out=0 and IDLE on the next edge. en dropped on the toggle cycle -> no period_start.
- half_period changed to 0 mid-run -> current half completes, then IDLE with wave_out=0. en=1 with half_period=0 from IDLE -> stays silent.
- nrst=0 asserted mid-high phase -> next edge gives wave_out=0, period_start=0, cnt=0. Releasing nrst with en=1 restarts with full entry latency.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg: shared octave type, state encoding and default divisor width for the tone blocks.
package synth_pkg;
  typedef logic [1:0] octave_t;
  localparam octave_t OCT_MAX = 2'd3;
  localparam int DIV_W_DEF = 16;
  typedef enum logic {IDLE, RUN} tone_state_t;
endpackage

// File: rtl/octave_period_calc.sv
// octave_period_calc: effective half-period = base half-period shifted up by the octave index.
module octave_period_calc
  import synth_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  localparam int CNT_W = DIV_W + 3
) (
  input  logic [DIV_W-1:0] half_period,
  input  octave_t          oct,
  output logic [CNT_W-1:0] eff
);
  // Widened before shifting so octave 3 cannot lose the top bits.
  assign eff = {3'b000, half_period} << oct;
endmodule

// File: rtl/octave_tone_gen.sv
// octave_tone_gen: octave-scaled square-wave generator; inputs are shadowed and applied at toggle boundaries.
// Optional OCTAVE_TONE_RESTART_EN: an octave change in RUN restarts the phase on the next edge.
module octave_tone_gen
  import synth_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  localparam int CNT_W = DIV_W + 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [DIV_W-1:0] half_period,
  input  logic [1:0]       oct_switch,
  output logic             wave_out,
  output logic             period_start
);
  tone_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_hp;
  octave_t          r_oct;
  logic             r_wave;
  logic             r_ps;
  logic [CNT_W-1:0] w_eff;
  logic             w_last;
  logic             w_hp_nz;
  octave_period_calc #(.DIV_W(DIV_W)) u_calc (
    .half_period(r_hp),
    .oct        (r_oct),
    .eff        (w_eff)
  );
  assign w_last  = r_cnt == w_eff - 1'b1;
  assign w_hp_nz = |half_period;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hp    <= '0;
      r_oct   <= '0;
      r_wave  <= 1'b0;
      r_ps    <= 1'b0;
    end else begin
      r_ps <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_wave <= 1'b0;
          if (en && w_hp_nz) begin
            r_state <= RUN;
            r_hp    <= half_period;
            r_oct   <= oct_switch;
          end
        end
        RUN:
          if (!en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wave  <= 1'b0;
          end
`ifdef OCTAVE_TONE_RESTART_EN
          else if (oct_switch != r_oct) begin
            r_cnt   <= '0;
            r_wave  <= 1'b0;
            r_hp    <= half_period;
            r_oct   <= oct_switch;
            r_state <= w_hp_nz ? RUN : IDLE;
          end
`endif
          else if (w_last) begin
            r_cnt <= '0;
            r_hp  <= half_period;
            r_oct <= oct_switch;
            // A zero relatched half-period silences at the boundary instead of toggling.
            if (w_hp_nz) begin
              r_wave <= ~r_wave;
              r_ps   <= ~r_wave;
            end else begin
              r_state <= IDLE;
              r_wave  <= 1'b0;
            end
          end else
            r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign wave_out     = r_wave;
  assign period_start = r_ps;
endmodule
